// File: rtl/video_timing_engine.sv
// Parametrised video timing engine: hs/vs/de generation, read-ahead pixel requests,
// RGB565/RGB888 expansion to 24-bit RGB and a frame-synchronous colour-bar generator.
module video_timing_engine #(
  parameter int unsigned H_SYNC  = 44,
  parameter int unsigned H_BACK  = 148,
  parameter int unsigned H_DISP  = 1280,
  parameter int unsigned H_FRONT = 88,
  parameter int unsigned V_SYNC  = 5,
  parameter int unsigned V_BACK  = 36,
  parameter int unsigned V_DISP  = 720,
  parameter int unsigned V_FRONT = 4,
  parameter logic        HS_POL  = 1'b1,
  parameter logic        VS_POL  = 1'b1,
  parameter int unsigned IN_FMT  = 0,
  parameter int unsigned RD_LAT  = 1,
  localparam int unsigned IN_W   = (IN_FMT == 1) ? 24 : 16
) (
  input  logic            pixel_clk,
  input  logic            sys_rst,
  input  logic            pattern_en,
  input  logic [IN_W-1:0] rd_data,
  output logic            data_req,
  output logic [11:0]     pixel_xpos,
  output logic [11:0]     pixel_ypos,
  output logic            frame_start,
  output logic            video_hs,
  output logic            video_vs,
  output logic            video_de,
  output logic [23:0]     video_rgb
);

  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HA0     = H_SYNC + H_BACK;
  localparam int unsigned VA0     = V_SYNC + V_BACK;
  localparam int unsigned BW      = H_DISP / 8;

  // h_cnt/v_cnt hold the position whose outputs are loaded at the next edge
  logic [CW-1:0] h_cnt, v_cnt, h_nxt, v_nxt, bar_cnt;
  logic [2:0]    bar_idx;
  logic          hs_c, vs_c, de_c, fs_c, mode, mode_n;
  logic [RD_LAT:0] hs_p, vs_p, de_p, pat_p;
  logic [2:0]    bar_p [RD_LAT+1];
  logic [23:0]   rd_wide, rgb_in;

  function automatic logic [23:0] bar_rgb(input logic [2:0] i);
    case (i)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  always_comb begin
    h_nxt = (h_cnt == CW'(H_TOTAL - 1)) ? '0 : h_cnt + CW'(1);
    v_nxt = v_cnt;
    if (h_cnt == CW'(H_TOTAL - 1))
      v_nxt = (v_cnt == CW'(V_TOTAL - 1)) ? '0 : v_cnt + CW'(1);
    hs_c   = h_cnt < CW'(H_SYNC);
    vs_c   = v_cnt < CW'(V_SYNC);
    de_c   = (h_cnt >= CW'(HA0)) && (h_cnt < CW'(HA0 + H_DISP)) &&
             (v_cnt >= CW'(VA0)) && (v_cnt < CW'(VA0 + V_DISP));
    fs_c   = (h_cnt == '0) && (v_cnt == '0);
    mode_n = frame_start ? pattern_en : mode;
    rd_wide = 24'(rd_data);
    // MSB replication so full-scale 565 maps to full-scale 888
    rgb_in = (IN_FMT == 1) ? rd_wide :
             {rd_wide[15:11], rd_wide[15:13], rd_wide[10:5], rd_wide[10:9],
              rd_wide[4:0], rd_wide[4:2]};
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode        <= 1'b0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      hs_p        <= '0;
      vs_p        <= '0;
      de_p        <= '0;
      pat_p       <= '0;
      for (int unsigned k = 0; k <= RD_LAT; k++) bar_p[k] <= '0;
      data_req    <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
      video_hs    <= ~HS_POL;
      video_vs    <= ~VS_POL;
      video_de    <= 1'b0;
      video_rgb   <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (frame_start) mode <= pattern_en;

      frame_start <= fs_c;
      data_req    <= de_c && !mode_n;
      pixel_xpos  <= de_c ? h_cnt - CW'(HA0) : '0;
      pixel_ypos  <= de_c ? v_cnt - CW'(VA0) : '0;

      // bar counter tracks the position in h_cnt; restarts at each line's first pixel
      if (h_nxt == CW'(HA0)) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (de_c) begin
        if (bar_cnt == CW'(BW - 1) && bar_idx != 3'd7) begin
          bar_idx <= bar_idx + 3'd1;
          bar_cnt <= '0;
        end else begin
          bar_cnt <= bar_cnt + CW'(1);
        end
      end

      hs_p[0]  <= hs_c;
      vs_p[0]  <= vs_c;
      de_p[0]  <= de_c;
      pat_p[0] <= mode_n;
      bar_p[0] <= bar_idx;
      for (int unsigned k = 1; k <= RD_LAT; k++) begin
        hs_p[k]  <= hs_p[k-1];
        vs_p[k]  <= vs_p[k-1];
        de_p[k]  <= de_p[k-1];
        pat_p[k] <= pat_p[k-1];
        bar_p[k] <= bar_p[k-1];
      end

      video_hs  <= hs_p[RD_LAT] ? HS_POL : ~HS_POL;
      video_vs  <= vs_p[RD_LAT] ? VS_POL : ~VS_POL;
      video_de  <= de_p[RD_LAT];
      video_rgb <= !de_p[RD_LAT] ? '0 :
                   pat_p[RD_LAT] ? bar_rgb(bar_p[RD_LAT]) : rgb_in;
    end
  end

endmodule

// File: tb/tb_video_timing_engine.sv
// Randomized bench for video_timing_engine against a frame-arithmetic reference model.
module tb_video_timing_engine;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pattern_en;
  logic [15:0] rd_data;

  logic        data_req, frame_start, video_hs, video_vs, video_de;
  logic [11:0] pixel_xpos, pixel_ypos;
  logic [23:0] video_rgb;
  logic        b_data_req, b_frame_start, b_hs, b_vs, b_de;
  logic [11:0] b_xpos, b_ypos;
  logic [23:0] b_rgb;

  int errors = 0;
  int checks = 0;

  logic [15:0] data_at [0:1023];
  logic        mode_of_frame [0:15];
  logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int first_req, first_de, req_f0, fs_cnt, b_hs_low, b_vs_low;

  video_timing_engine #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .IN_FMT(0), .RD_LAT(2)
  ) dut (
    .pixel_clk(clk), .sys_rst(rst), .pattern_en(pattern_en), .rd_data(rd_data),
    .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start), .video_hs(video_hs), .video_vs(video_vs),
    .video_de(video_de), .video_rgb(video_rgb)
  );

  video_timing_engine #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .IN_FMT(0), .RD_LAT(2)
  ) dut_neg (
    .pixel_clk(clk), .sys_rst(rst), .pattern_en(pattern_en), .rd_data(rd_data),
    .data_req(b_data_req), .pixel_xpos(b_xpos), .pixel_ypos(b_ypos),
    .frame_start(b_frame_start), .video_hs(b_hs), .video_vs(b_vs),
    .video_de(b_de), .video_rgb(b_rgb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int hpos(int n); return (n % FT) % HT; endfunction
  function automatic int vpos(int n); return (n % FT) / HT; endfunction
  function automatic bit m_de(int n);
    if (n < 0) return 1'b0;
    return hpos(n) >= 4 && hpos(n) < 12 && vpos(n) >= 2 && vpos(n) < 6;
  endfunction
  function automatic bit m_hs(int n); return n >= 0 && hpos(n) < 2; endfunction
  function automatic bit m_vs(int n); return n >= 0 && vpos(n) < 1; endfunction

  function automatic logic [23:0] m_exp(input logic [15:0] d);
    int r, g, b;
    r = int'(d[15:11]); g = int'(d[10:5]); b = int'(d[4:0]);
    return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
  endfunction

  function automatic logic [23:0] m_rgb(int n);
    int x;
    if (!m_de(n)) return 24'h0;
    if (mode_of_frame[n / FT]) begin
      x = hpos(n) - 4;
      return bars[(x > 7) ? 7 : x];
    end
    return m_exp(data_at[n + 2]);
  endfunction

  task automatic check_cycle(input int t);
    int n;
    bit de_t;
    n = t - LAT;
    de_t = m_de(t);
    check("frame_start", 32'(frame_start), 32'(t % FT == 0));
    check("data_req", 32'(data_req), 32'(de_t ? !mode_of_frame[t / FT] : 1'b0));
    check("xpos", 32'(pixel_xpos), de_t ? 32'(hpos(t) - 4) : 32'd0);
    check("ypos", 32'(pixel_ypos), de_t ? 32'(vpos(t) - 2) : 32'd0);
    check("video_de", 32'(video_de), 32'(m_de(n)));
    check("video_hs", 32'(video_hs), 32'(m_hs(n)));
    check("video_vs", 32'(video_vs), 32'(m_vs(n)));
    check("video_rgb", 32'(video_rgb), 32'(m_rgb(n)));
    check("neg_hs", 32'(b_hs), 32'(!m_hs(n)));
    check("neg_vs", 32'(b_vs), 32'(!m_vs(n)));
    if (data_req && first_req < 0) first_req = t;
    if (video_de && first_de < 0) first_de = t;
    if (data_req && t < FT) req_f0++;
    if (frame_start) fs_cnt++;
    if (t >= FT && t < 2 * FT) begin
      if (!b_hs) b_hs_low++;
      if (!b_vs) b_vs_low++;
    end
  endtask

  function automatic logic pat_drive(int seg, int t);
    int f, pos;
    f = t / FT; pos = t % FT;
    if (f == 0) return 1'b0;
    if (seg == 1 && f == 1) return pos >= 50;
    if (seg == 1 && f == 2) return pos < 50;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_req"}, 32'(data_req), 32'd0);
    check({tag, "_xpos"}, 32'(pixel_xpos), 32'd0);
    check({tag, "_ypos"}, 32'(pixel_ypos), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_de"}, 32'(video_de), 32'd0);
    check({tag, "_rgb"}, 32'(video_rgb), 32'd0);
    check({tag, "_hs"}, 32'(video_hs), 32'd0);
    check({tag, "_vs"}, 32'(video_vs), 32'd0);
    check({tag, "_neg_hs"}, 32'(b_hs), 32'd1);
    check({tag, "_neg_vs"}, 32'(b_vs), 32'd1);
  endtask

  task automatic run_seg(input int seg, input int len);
    for (int i = 0; i < 1024; i++) data_at[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) mode_of_frame[i] = 1'b0;
    if (seg == 1) begin
      data_at[34] = 16'hF800;
      data_at[35] = 16'h0841;
      data_at[36] = 16'h0821;
      data_at[37] = 16'hFFFF;
    end
    first_req = -1; first_de = -1; req_f0 = 0; fs_cnt = 0; b_hs_low = 0; b_vs_low = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int t = 0; t < len; t++) begin
      check_cycle(t);
      if (seg == 1 && t == 35) check("rgb_F800", 32'(video_rgb), 32'h00FF0000);
      if (seg == 1 && t == 36) check("rgb_0841", 32'(video_rgb), 32'h00080808);
      if (seg == 1 && t == 37) check("rgb_0821", 32'(video_rgb), 32'h00080408);
      if (seg == 1 && t == 38) check("rgb_FFFF", 32'(video_rgb), 32'h00FFFFFF);
      pattern_en = pat_drive(seg, t);
      if (t % FT == 0) mode_of_frame[t / FT] = pattern_en;
      rd_data = data_at[t];
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    pattern_en = 1'b0;
    rd_data = 16'h0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset");

    run_seg(1, 627);
    check("first_req_cycle", 32'(first_req), 32'd32);
    check("first_de_cycle", 32'(first_de), 32'd35);
    check("req_frame0", 32'(req_f0), 32'd32);
    check("frame_starts", 32'(fs_cnt), 32'd7);
    check("neg_hs_low", 32'(b_hs_low), 32'd14);
    check("neg_vs_low", 32'(b_vs_low), 32'd14);

    // cycle 627 lies mid-line with the delayed de active
    check_cycle(627);
    check("pre_rst_de", 32'(video_de), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    repeat (2) @(posedge clk);
    #1 check_reset("held_rst");

    run_seg(2, 300);
    check("seg2_first_req", 32'(first_req), 32'd32);
    check("seg2_first_de", 32'(first_de), 32'd35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
